// File: rtl/video_pattern_gen.sv
// video_pattern_gen
// Frame-timing and test-pattern generator. A start request latches the
// timing/pattern configuration and produces N frames (or runs until stopped
// when the frame count is 0) of registered sync, data-enable and pixel data.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   i_start / i_stop    start a frame sequence (IDLE only) / finish frame, stop
//   i_mode              0: x ramp, 1: y ramp, 2: solid i_color, 3: 8x8 checker
//   i_h_active..i_vfp   active sizes and porches (cycles / lines)
//   i_frames            frame count, 0 = continuous
//   i_color             solid colour
//   o_vs/o_hs/o_de      registered sync pulses and data enable
//   o_data              registered pixel data, 0 outside the active window
//   o_busy              high whenever not IDLE
//   o_frame_done        one-cycle pulse on the last output cycle of a frame
//   o_frame_cnt         completed-frame counter (only with PATGEN_FRAME_CNT_EN)
//
// Optional feature: define PATGEN_FRAME_CNT_EN to add o_frame_cnt.
//
// state    | meaning
// ST_IDLE  | waiting for an acceptable start request, outputs held at 0
// ST_RUN   | generating frames
// ST_DRAIN | stop seen, finishing the current frame
module video_pattern_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic [1:0]                   i_mode,
    input  logic [CNT_WIDTH-1:0]         i_h_active,
    input  logic [CNT_WIDTH-1:0]         i_v_active,
    input  logic [CNT_WIDTH-1:0]         i_hbp,
    input  logic [CNT_WIDTH-1:0]         i_hfp,
    input  logic [CNT_WIDTH-1:0]         i_vbp,
    input  logic [CNT_WIDTH-1:0]         i_vfp,
    input  logic [15:0]                  i_frames,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_color,
    output logic                         o_vs,
    output logic                         o_hs,
    output logic                         o_de,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic                         o_busy,
`ifdef PATGEN_FRAME_CNT_EN
    output logic [15:0]                  o_frame_cnt,
`endif
    output logic                         o_frame_done
);

    localparam int CW = CNT_WIDTH + 2;
    localparam int PW = NUM_CH * DATA_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_hc, r_vc, w_hc_n, w_vc_n;
    logic [CW-1:0]   r_ht, r_vt, r_h_active, r_v_active, r_hbp, r_vbp;
    logic [1:0]      r_mode;
    logic [PW-1:0]   r_color;
    logic [15:0]     r_frames_left, w_frames_left_n;

    logic            w_accept, w_hc_last, w_vc_last, w_run_n, w_de_n, w_fd_n;
    logic [CW-1:0]   w_ht_n, w_vt_n, w_ha_n, w_va_n, w_hbp_n, w_vbp_n;
    logic [CW-1:0]   w_ht_start, w_vt_start;
    logic [1:0]      w_mode_n;
    logic [PW-1:0]   w_color_n, w_data_n;
    logic [DATA_WIDTH-1:0] w_x, w_y;

    assign w_accept   = (r_state == ST_IDLE) && i_start &&
                        (i_h_active != '0) && (i_v_active != '0);
    assign w_ht_start = {2'b00, i_hbp} + {2'b00, i_h_active} + {2'b00, i_hfp};
    assign w_vt_start = {2'b00, i_vbp} + {2'b00, i_v_active} + {2'b00, i_vfp};
    assign w_hc_last  = (r_hc == r_ht - 1'b1);
    assign w_vc_last  = (r_vc == r_vt - 1'b1);
    assign o_busy     = (r_state != ST_IDLE);

    always_comb begin
        w_state_n       = r_state;
        w_hc_n          = r_hc;
        w_vc_n          = r_vc;
        w_frames_left_n = r_frames_left;
        case (r_state)
            ST_IDLE: begin
                w_hc_n = '0;
                w_vc_n = '0;
                if (w_accept) begin
                    w_state_n       = ST_RUN;
                    w_frames_left_n = i_frames;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_hc_last) begin
                    w_hc_n = '0;
                    w_vc_n = w_vc_last ? '0 : r_vc + 1'b1;
                end else begin
                    w_hc_n = r_hc + 1'b1;
                end
                if (w_hc_last && w_vc_last) begin
                    // A stop on the very last cycle ends here, no extra frame.
                    if (r_state == ST_DRAIN || i_stop || r_frames_left == 16'd1)
                        w_state_n = ST_IDLE;
                    if (r_frames_left > 16'd1)
                        w_frames_left_n = r_frames_left - 16'd1;
                end else if (r_state == ST_RUN && i_stop) begin
                    w_state_n = ST_DRAIN;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the position being entered, so on the
    // start edge the configuration comes straight from the inputs.
    assign w_ht_n    = w_accept ? w_ht_start         : r_ht;
    assign w_vt_n    = w_accept ? w_vt_start         : r_vt;
    assign w_ha_n    = w_accept ? {2'b00, i_h_active} : r_h_active;
    assign w_va_n    = w_accept ? {2'b00, i_v_active} : r_v_active;
    assign w_hbp_n   = w_accept ? {2'b00, i_hbp}      : r_hbp;
    assign w_vbp_n   = w_accept ? {2'b00, i_vbp}      : r_vbp;
    assign w_mode_n  = w_accept ? i_mode              : r_mode;
    assign w_color_n = w_accept ? i_color             : r_color;

    assign w_run_n = (w_state_n != ST_IDLE);
    assign w_de_n  = w_run_n &&
                     (w_vc_n >= w_vbp_n) && (w_vc_n < w_vbp_n + w_va_n) &&
                     (w_hc_n >= w_hbp_n) && (w_hc_n < w_hbp_n + w_ha_n);
    assign w_fd_n  = w_run_n && (w_hc_n == w_ht_n - 1'b1) && (w_vc_n == w_vt_n - 1'b1);

    // Truncated subtraction gives the same low bits as subtracting full width.
    assign w_x = w_hc_n[DATA_WIDTH-1:0] - w_hbp_n[DATA_WIDTH-1:0];
    assign w_y = w_vc_n[DATA_WIDTH-1:0] - w_vbp_n[DATA_WIDTH-1:0];

    always_comb begin
        w_data_n = '0;
        if (w_de_n) begin
            case (w_mode_n)
                2'd0:    w_data_n = {NUM_CH{w_x}};
                2'd1:    w_data_n = {NUM_CH{w_y}};
                2'd2:    w_data_n = w_color_n;
                default: w_data_n = (w_x[3] ^ w_y[3]) ? '1 : '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hc          <= '0;
            r_vc          <= '0;
            r_frames_left <= '0;
            r_ht          <= '0;
            r_vt          <= '0;
            r_h_active    <= '0;
            r_v_active    <= '0;
            r_hbp         <= '0;
            r_vbp         <= '0;
            r_mode        <= '0;
            r_color       <= '0;
            o_vs          <= 1'b0;
            o_hs          <= 1'b0;
            o_de          <= 1'b0;
            o_data        <= '0;
            o_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_hc          <= w_hc_n;
            r_vc          <= w_vc_n;
            r_frames_left <= w_frames_left_n;
            if (w_accept) begin
                r_ht       <= w_ht_start;
                r_vt       <= w_vt_start;
                r_h_active <= {2'b00, i_h_active};
                r_v_active <= {2'b00, i_v_active};
                r_hbp      <= {2'b00, i_hbp};
                r_vbp      <= {2'b00, i_vbp};
                r_mode     <= i_mode;
                r_color    <= i_color;
            end
            o_vs         <= w_run_n && (w_vc_n == '0);
            o_hs         <= w_run_n && (w_hc_n == '0);
            o_de         <= w_de_n;
            o_data       <= w_data_n;
            o_frame_done <= w_fd_n;
        end
    end

`ifdef PATGEN_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || w_accept)
            o_frame_cnt <= '0;
        else if (o_frame_done)
            o_frame_cnt <= o_frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen (default parameters: 24-bit o_data).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_stop;
    logic [1:0]  i_mode;
    logic [11:0] i_h_active, i_v_active, i_hbp, i_hfp, i_vbp, i_vfp;
    logic [15:0] i_frames;
    logic [23:0] i_color;
    logic        o_vs, o_hs, o_de, o_busy, o_frame_done;
    logic [23:0] o_data;
`ifdef PATGEN_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_pattern_gen dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .i_h_active   (i_h_active),
        .i_v_active   (i_v_active),
        .i_hbp        (i_hbp),
        .i_hfp        (i_hfp),
        .i_vbp        (i_vbp),
        .i_vfp        (i_vfp),
        .i_frames     (i_frames),
        .i_color      (i_color),
        .o_vs         (o_vs),
        .o_hs         (o_hs),
        .o_de         (o_de),
        .o_data       (o_data),
        .o_busy       (o_busy),
`ifdef PATGEN_FRAME_CNT_EN
        .o_frame_cnt  (o_frame_cnt),
`endif
        .o_frame_done (o_frame_done)
    );

    task automatic set_cfg(input logic [11:0] ha, va, porch, input logic [15:0] fr,
                           input logic [1:0] md);
        i_h_active = ha; i_v_active = va;
        i_hbp = porch; i_hfp = porch; i_vbp = porch; i_vfp = porch;
        i_frames = fr; i_mode = md;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 0; i_stop = 0; i_color = 24'h0;
        set_cfg(12'd0, 12'd0, 12'd0, 16'd0, 2'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({o_vs, o_hs, o_de, o_busy, o_frame_done} !== 5'b0 || o_data !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs got ctl=%b data=%h required all zero",
                     {o_vs, o_hs, o_de, o_busy, o_frame_done}, o_data);
        end
`ifdef PATGEN_FRAME_CNT_EN
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_cnt got=%0d required=0", o_frame_cnt);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    // HT=10, VT=8, one frame, x ramp.
    task automatic test_basic();
        int hc, vc, nfd;
        logic [4:0]  exp_ctl;
        logic [23:0] exp_d;
        logic [7:0]  x;
        set_cfg(12'd4, 12'd2, 12'd3, 16'd1, 2'd0);
        i_start = 1; @(negedge clk); i_start = 0;
        nfd = 0;
        for (int c = 0; c < 85; c++) begin
            hc = c % 10; vc = c / 10;
            exp_ctl = '0; exp_d = '0;
            if (c < 80) begin
                exp_ctl[4] = 1'b1;
                exp_ctl[3] = (hc == 0);
                exp_ctl[2] = (vc == 0);
                exp_ctl[1] = (vc >= 3 && vc < 5 && hc >= 3 && hc < 7);
                exp_ctl[0] = (c == 79);
                if (exp_ctl[1]) begin x = 8'(hc - 3); exp_d = {3{x}}; end
            end
            checks++;
            if ({o_busy, o_hs, o_vs, o_de, o_frame_done} !== exp_ctl) begin
                failures++;
                $display("FAIL basic_ctl c=%0d got busy/hs/vs/de/fd=%b required=%b", c,
                         {o_busy, o_hs, o_vs, o_de, o_frame_done}, exp_ctl);
            end
            checks++;
            if (o_data !== exp_d) begin
                failures++;
                $display("FAIL basic_data c=%0d got=%h required=%h", c, o_data, exp_d);
            end
            nfd = nfd + int'(o_frame_done);
            @(negedge clk);
        end
        checks++;
        if (nfd != 1) begin
            failures++;
            $display("FAIL basic_frame_done_count got=%0d required=1", nfd);
        end
    endtask

    // HT=6, VT=4 (24 cycles/frame), continuous solid colour, stop in frame 3 line 1.
    task automatic test_continuous_stop();
        int hc, vc, nfd, nde;
        logic exp_de, exp_busy;
        set_cfg(12'd4, 12'd2, 12'd1, 16'd0, 2'd2);
        i_color = 24'h102030;
        i_start = 1; @(negedge clk); i_start = 0;
        nfd = 0; nde = 0;
        for (int c = 0; c < 80; c++) begin
            hc = c % 6; vc = (c / 6) % 4;
            exp_busy = (c < 72);
            exp_de   = exp_busy && vc >= 1 && vc < 3 && hc >= 1 && hc < 5;
            checks++;
            if (o_busy !== exp_busy || o_de !== exp_de) begin
                failures++;
                $display("FAIL cont_ctl c=%0d got busy=%b de=%b required busy=%b de=%b",
                         c, o_busy, o_de, exp_busy, exp_de);
            end
            checks++;
            if (o_data !== (exp_de ? 24'h102030 : 24'h0)) begin
                failures++;
                $display("FAIL cont_data c=%0d got=%h required=%h", c, o_data,
                         exp_de ? 24'h102030 : 24'h0);
            end
            nfd = nfd + int'(o_frame_done);
            nde = nde + int'(o_de);
            i_stop = (c == 54);
            @(negedge clk);
        end
        i_stop = 0;
        checks++;
        if (nfd != 3 || nde != 24) begin
            failures++;
            $display("FAIL cont_counts got frame_done=%0d de=%0d required 3 and 24", nfd, nde);
        end
    endtask

    // 16x16, no porches, checkerboard.
    task automatic test_checker();
        int nfd;
        set_cfg(12'd16, 12'd16, 12'd0, 16'd1, 2'd3);
        i_start = 1; @(negedge clk); i_start = 0;
        nfd = 0;
        for (int c = 0; c < 260; c++) begin
            if (c == 0 || c == 7 || c == 8 || c == 128 || c == 136) begin
                logic [23:0] exp_d;
                exp_d = (c == 8 || c == 128) ? 24'hFFFFFF : 24'h0;
                checks++;
                if (o_data !== exp_d || o_de !== 1'b1) begin
                    failures++;
                    $display("FAIL checker_data c=%0d got de=%b data=%h required de=1 data=%h",
                             c, o_de, o_data, exp_d);
                end
            end
            if (o_frame_done && c != 255) begin
                failures++;
                $display("FAIL checker_fd_position got pulse at c=%0d required c=255", c);
            end
            nfd = nfd + int'(o_frame_done);
            if (c == 256) begin
                checks++;
                if (o_busy !== 1'b0 || nfd != 1) begin
                    failures++;
                    $display("FAIL checker_end got busy=%b fd=%0d required busy=0 fd=1", o_busy, nfd);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        int nfd;
        set_cfg(12'd4, 12'd2, 12'd3, 16'd1, 2'd0);
        i_start = 1; @(negedge clk); i_start = 0;
        repeat (34) @(negedge clk);
        checks++;
        if (o_de !== 1'b1 || o_data !== 24'h010101) begin
            failures++;
            $display("FAIL midreset_pre got de=%b data=%h required de=1 data=010101", o_de, o_data);
        end
        rst = 1; @(negedge clk);
        checks++;
        if ({o_vs, o_hs, o_de, o_busy, o_frame_done} !== 5'b0 || o_data !== 24'h0) begin
            failures++;
            $display("FAIL midreset_outputs got ctl=%b data=%h required all zero",
                     {o_vs, o_hs, o_de, o_busy, o_frame_done}, o_data);
        end
        rst = 0;
        nfd = 0;
        for (int c = 0; c < 10; c++) begin
            nfd = nfd + int'(o_frame_done) + int'(o_busy);
            @(negedge clk);
        end
        checks++;
        if (nfd != 0) begin
            failures++;
            $display("FAIL midreset_quiet got fd+busy=%0d required=0", nfd);
        end
        i_start = 1; @(negedge clk); i_start = 0;
        checks++;
        if ({o_busy, o_hs, o_vs, o_de} !== 4'b1110) begin
            failures++;
            $display("FAIL midreset_restart got busy/hs/vs/de=%b required=1110",
                     {o_busy, o_hs, o_vs, o_de});
        end
        repeat (34) @(negedge clk);
        checks++;
        if (o_data !== 24'h010101) begin
            failures++;
            $display("FAIL midreset_restart_data got=%h required=010101", o_data);
        end
        for (int c = 0; c < 100 && o_busy; c++) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_timeout got busy=%b required=0", o_busy);
        end
    endtask

    task automatic test_zero_and_ignore();
        int nbusy, nfd;
        logic exp_de;
        set_cfg(12'd0, 12'd2, 12'd3, 16'd1, 2'd0);
        i_start = 1; @(negedge clk);
        i_h_active = 12'd4; i_v_active = 12'd0; @(negedge clk); i_start = 0;
        nbusy = 0;
        for (int c = 0; c < 3; c++) begin
            nbusy = nbusy + int'(o_busy);
            @(negedge clk);
        end
        checks++;
        if (nbusy != 0) begin
            failures++;
            $display("FAIL zero_size_busy got busy cycles=%0d required=0", nbusy);
        end
        set_cfg(12'd4, 12'd2, 12'd3, 16'd1, 2'd1);
        i_start = 1; @(negedge clk); i_start = 0;
        nfd = 0;
        for (int c = 0; c < 82; c++) begin
            exp_de = (c < 80) && (c / 10 >= 3) && (c / 10 < 5) && (c % 10 >= 3) && (c % 10 < 7);
            checks++;
            if (o_busy !== (c < 80) || o_de !== exp_de ||
                o_data !== (exp_de ? {3{8'(c / 10 - 3)}} : 24'h0)) begin
                failures++;
                $display("FAIL ignore_stream c=%0d got busy=%b de=%b data=%h required busy=%b de=%b",
                         c, o_busy, o_de, o_data, (c < 80), exp_de);
            end
            nfd = nfd + int'(o_frame_done);
            if (c == 5) begin
                set_cfg(12'd7, 12'd5, 12'd0, 16'd3, 2'd0);
                i_start = 1;
            end
            if (c == 6) i_start = 0;
            @(negedge clk);
        end
        checks++;
        if (nfd != 1) begin
            failures++;
            $display("FAIL ignore_frame_done got=%0d required=1", nfd);
        end
    endtask

`ifdef PATGEN_FRAME_CNT_EN
    task automatic test_frame_cnt();
        set_cfg(12'd4, 12'd2, 12'd3, 16'd5, 2'd0);
        i_start = 1; @(negedge clk); i_start = 0;
        for (int c = 0; c < 500 && o_busy; c++) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_frame_cnt !== 16'd5) begin
            failures++;
            $display("FAIL frame_cnt_five got busy=%b cnt=%0d required busy=0 cnt=5", o_busy, o_frame_cnt);
        end
        i_frames = 16'd0;
        i_start = 1; @(negedge clk); i_start = 0;
        checks++;
        if (o_frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL frame_cnt_clear got=%0d required=0", o_frame_cnt);
        end
        i_stop = 1; @(negedge clk); i_stop = 0;
        for (int c = 0; c < 200 && o_busy; c++) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL frame_cnt_drain got busy=%b cnt=%0d required busy=0 cnt=1", o_busy, o_frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_continuous_stop();
        test_checker();
        test_reset_midframe();
        test_zero_and_ignore();
`ifdef PATGEN_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
